serial_subtractor: RTL and testbench

Bit-serial subtractor that computes A − B − borrow-in using one full-subtractor cell and a borrow flip-flop. It processes one bit per clock, LSB first, and uses a start/busy/done handshake. It is the inverse-operation companion to the team's full-adder blocks: the same single-bit cell is reused across WIDTH cycles instead of being replicated. Operands load in parallel; the result is presented in parallel and held until the next operation completes.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and parallel operand/result bus of the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             B_out;

  modport master (
    output start, A, B, B_in,
    input  busy, done, D, B_out
  );

  modport slave (
    input  start, A, B, B_in,
    output busy, done, D, B_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flip-flop reused over WIDTH
// clocks, LSB first, computing {B_out, D} = A - B - B_in with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] res_reg;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;

  logic             x;
  logic             y;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    x         = a_reg[0];
    y         = b_reg[0];
    d_bit     = x ^ y ^ br;
    br_next   = (~x & y) | (~(x ^ y) & br);
    // Only WIDTH-1 result bits are stored; the current bit completes the word on the last step.
    res_shift = {d_bit, res_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      d_r     <= '0;
      bout_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_reg  <= bus.A;
            b_reg  <= bus.B;
            br     <= bus.B_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_reg <= res_shift[WIDTH-1:1];
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br      <= br_next;
          cnt     <= cnt + CNT_W'(1);
          // D and B_out are only updated here, so they hold the previous result during SHIFT.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            d_r    <= res_shift;
            bout_r <= br_next;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.D     = d_r;
  assign bus.B_out = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: WIDTH=8 directed/handshake/reset/random tests plus a WIDTH=4 exhaustive sweep,
// each result compared with plain-arithmetic subtraction A - B - B_in.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n8 = 1'b0;
  logic rst_n4 = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [8:0] res;
  } op_t;

  op_t        exp8[$];
  op_t        exp4[$];
  logic [7:0] last_d8 = 8'h00;
  int         done_seen8 = 0;
  bit         w4_finished = 0;

  // Unsigned subtraction wrapped to WIDTH+1 bits: {B_out, D}.
  function automatic logic [8:0] model(input int width, input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    r = r + (1 << (width + 1));
    r = r % (1 << (width + 1));
    return r[8:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 40; i++) begin
      if (!bus8.busy && !bus8.done) break;
      @(negedge clk);
    end
    check_output("idle8_reached", {30'd0, bus8.busy, bus8.done}, 32'd0);
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic bin);
    op_t op;
    wait_idle8();
    op.a = a; op.b = b; op.bin = bin;
    op.res = model(8, a, b, bin);
    bus8.A = a; bus8.B = b; bus8.B_in = bin; bus8.start = 1'b1;
    exp8.push_back(op);
    @(negedge clk);
    bus8.start = 1'b0;
    check_output("accept_busy", {30'd0, bus8.busy, bus8.done}, 32'd2);
    check_output("d_held_in_shift", {24'd0, bus8.D}, {24'd0, last_d8});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) check_output("shift_busy", {30'd0, bus8.busy, bus8.done}, 32'd2);
      else       check_output("done_latency", {30'd0, bus8.busy, bus8.done}, 32'd1);
    end
    last_d8 = op.res[7:0];
  endtask

  // Scoreboard monitor for the 8-bit instance.
  initial begin
    op_t op;
    forever begin
      @(negedge clk);
      if (rst_n8) begin
        if (bus8.busy && bus8.done) check_output("busy_done_overlap8", 32'd1, 32'd0);
        if (bus8.done) begin
          done_seen8++;
          if (exp8.size() == 0) begin
            check_output("unexpected_done8", {23'd0, bus8.B_out, bus8.D}, 32'h1ff);
          end else begin
            op = exp8.pop_front();
            check_output("result8", {23'd0, bus8.B_out, bus8.D}, {23'd0, op.res});
          end
        end
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance, logging each completed operation.
  initial begin
    op_t op;
    forever begin
      @(negedge clk);
      if (rst_n4 && bus4.done) begin
        if (exp4.size() == 0) begin
          check_output("unexpected_done4", {27'd0, bus4.B_out, bus4.D}, 32'h1f);
        end else begin
          op = exp4.pop_front();
          $display("[TB] w4 t=%0t A=%h B=%h B_in=%b -> D=%h B_out=%b", $time,
                   op.a[3:0], op.b[3:0], op.bin, bus4.D, bus4.B_out);
          check_output("result4", {27'd0, bus4.B_out, bus4.D}, {23'd0, op.res});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Exhaustive sweep of the 4-bit instance.
  initial begin
    op_t op;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.B_in = 1'b0;
    #3;
    check_output("reset4", {27'd0, bus4.busy, bus4.done, bus4.D}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          for (int i = 0; i < 20 && (bus4.busy || bus4.done); i++) @(negedge clk);
          op.a = 8'(a); op.b = 8'(b); op.bin = bin[0];
          op.res = model(4, a, b, bin);
          bus4.A = 4'(a); bus4.B = 4'(b); bus4.B_in = bin[0]; bus4.start = 1'b1;
          exp4.push_back(op);
          @(negedge clk);
          bus4.start = 1'b0;
        end
      end
    end
    for (int i = 0; i < 20 && exp4.size() != 0; i++) @(negedge clk);
    check_output("w4_queue_drained", exp4.size(), 32'd0);
    w4_finished = 1;
  end

  // Directed, handshake, reset and random tests of the 8-bit instance.
  initial begin
    op_t op;
    int  dones;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.B_in = 1'b0;
    #3;
    check_output("reset8", {22'd0, bus8.busy, bus8.done, bus8.B_out, bus8.D}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n8 = 1'b1;
    @(negedge clk);
    check_output("idle_after_reset8", {22'd0, bus8.busy, bus8.done, bus8.B_out, bus8.D}, 32'd0);

    apply_stimulus(8'h05, 8'h03, 1'b0);
    apply_stimulus(8'h03, 8'h05, 1'b0);
    apply_stimulus(8'h00, 8'h00, 1'b1);
    apply_stimulus(8'hFF, 8'h00, 1'b0);
    apply_stimulus(8'hFF, 8'hFF, 1'b1);

    // Start pulsed during SHIFT is ignored; start then held so the next op follows DONE directly.
    wait_idle8();
    op.a = 8'h10; op.b = 8'h01; op.bin = 1'b0; op.res = model(8, 16, 1, 0);
    exp8.push_back(op);
    bus8.A = 8'h10; bus8.B = 8'h01; bus8.B_in = 1'b0; bus8.start = 1'b1;
    dones = done_seen8;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.A = 8'h00; bus8.B = 8'h00; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check_output("pulse_ignored_busy", {31'd0, bus8.busy}, 32'd1);
    repeat (4) @(negedge clk);
    op.a = 8'h20; op.b = 8'h05; op.bin = 1'b1; op.res = model(8, 32, 5, 1);
    exp8.push_back(op);
    bus8.A = 8'h20; bus8.B = 8'h05; bus8.B_in = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    check_output("held_busy_before_done", {30'd0, bus8.busy, bus8.done}, 32'd2);
    @(negedge clk);
    check_output("held_done", {30'd0, bus8.busy, bus8.done}, 32'd1);
    check_output("single_done_first", done_seen8 - dones, 32'd1);
    @(negedge clk);
    check_output("held_idle_gap", {30'd0, bus8.busy, bus8.done}, 32'd0);
    @(negedge clk);
    check_output("held_accept", {30'd0, bus8.busy, bus8.done}, 32'd2);
    bus8.start = 1'b0;
    repeat (7) @(negedge clk);
    check_output("held_busy_before_done2", {30'd0, bus8.busy, bus8.done}, 32'd2);
    @(negedge clk);
    check_output("held_done2", {30'd0, bus8.busy, bus8.done}, 32'd1);
    last_d8 = 8'h1A;

    // Reset asserted after bit-step 4 aborts the operation immediately.
    wait_idle8();
    bus8.A = 8'h9C; bus8.B = 8'h31; bus8.B_in = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("pre_abort_d", {24'd0, bus8.D}, 32'h1A);
    #2 rst_n8 = 1'b0;
    #1 check_output("abort_outputs", {22'd0, bus8.busy, bus8.done, bus8.B_out, bus8.D}, 32'd0);
    @(negedge clk);
    rst_n8 = 1'b1;
    dones = done_seen8;
    repeat (12) @(negedge clk);
    check_output("no_done_after_abort", done_seen8 - dones, 32'd0);
    last_d8 = 8'h00;
    apply_stimulus(8'h37, 8'h12, 1'b1);

    for (int i = 0; i < 25; i++)
      apply_stimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check_output("w8_queue_drained", exp8.size(), 32'd0);
    for (int i = 0; i < 5000 && !w4_finished; i++) @(negedge clk);
    check_output("w4_finished", {31'd0, w4_finished}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
